// File: rtl/ahb_arb_pkg.sv
// Shared constants and types for the AHB bus arbiter: transfer types,
// response codes and the arbitration state encoding.
package ahb_arb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    // PARK: default master holds the bus with nobody asking for it.
    // GRANT: an unlocked owner holds the bus.
    // LOCK: the owner runs a locked sequence and the grant is frozen.
    typedef enum logic [1:0] {
        PARK  = 2'd0,
        GRANT = 2'd1,
        LOCK  = 2'd2
    } arb_state_t;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: returns the first requesting master
// strictly after the pointer, wrapping around, so the pointer's own master
// is considered last.
module rr_picker #(
    parameter int NoOfMasters = 3,
    parameter int PtrWidth    = $clog2(NoOfMasters)
) (
    input  logic [NoOfMasters-1:0] i_req,
    input  logic [PtrWidth-1:0]    i_ptr,
    output logic [PtrWidth-1:0]    o_winner,
    output logic                   o_valid
);

    localparam int SW = PtrWidth + 1;

    logic [SW-1:0]       w_sum;
    logic [PtrWidth-1:0] w_cand;

    // Walk from the farthest candidate back to the nearest one so that the
    // last hit, which is the nearest requester after the pointer, wins.
    always_comb begin
        o_winner = '0;
        o_valid  = 1'b0;
        w_sum    = '0;
        w_cand   = '0;
        for (int k = NoOfMasters; k >= 1; k--) begin
            w_sum = {1'b0, i_ptr} + SW'(k);
            if (w_sum >= SW'(NoOfMasters)) begin
                w_cand = PtrWidth'(w_sum - SW'(NoOfMasters));
            end else begin
                w_cand = PtrWidth'(w_sum);
            end
            if (i_req[w_cand]) begin
                o_winner = w_cand;
                o_valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ahb_bus_arbiter.sv
// Multi-master AHB arbiter: round-robin grant with burst protection,
// locked sequences, a beat limit against bus hogging, and registered
// address-phase ownership (HMASTER/HMASTLOCK) trailing the grant.
module ahb_bus_arbiter
    import ahb_arb_pkg::*;
#(
    parameter int NoOfMasters   = 3,
    parameter int DefaultMaster = 0,
    parameter int MaxBeats      = 16
) (
    input  logic                             HCLK,
    input  logic                             HRESET,
    input  logic [NoOfMasters-1:0]           HBUSREQ,
    input  logic [NoOfMasters-1:0]           HLOCK,
    input  logic [1:0]                       HTRANS,
    input  logic                             HREADY,
    input  logic                             HRESP,
    output logic [NoOfMasters-1:0]           HGRANT,
    output logic [$clog2(NoOfMasters)-1:0]   HMASTER,
    output logic                             HMASTLOCK
);

    localparam int MW = $clog2(NoOfMasters);
    localparam int BW = (MaxBeats > 1) ? $clog2(MaxBeats) : 1;

    localparam logic [MW-1:0]          DEF_IDX   = MW'(DefaultMaster);
    localparam logic [NoOfMasters-1:0] GRANT_ONE = NoOfMasters'(1);
    localparam logic [NoOfMasters-1:0] DEF_GRANT = GRANT_ONE << DefaultMaster;
    localparam logic [BW-1:0]          BEAT_LAST = BW'(MaxBeats - 1);

    arb_state_t             r_state;
    logic [NoOfMasters-1:0] r_grant;
    logic [MW-1:0]          r_owner;
    logic [MW-1:0]          r_rrPtr;
    logic [BW-1:0]          r_beats;
    logic [MW-1:0]          r_master;
    logic                   r_mastLock;

    logic [MW-1:0]          w_winner;
    logic                   w_winValid;
    logic                   w_isBurst;
    logic                   w_isActive;
    logic                   w_isErr;
    logic                   w_othersReq;
    logic                   w_beatLimit;
    logic                   w_rearb;
    logic                   w_ownerLocks;

    arb_state_t             w_nextState;
    logic [NoOfMasters-1:0] w_nextGrant;
    logic [MW-1:0]          w_nextOwner;
    logic [MW-1:0]          w_nextPtr;
    logic [BW-1:0]          w_nextBeats;

    rr_picker #(
        .NoOfMasters (NoOfMasters),
        .PtrWidth    (MW)
    ) u_picker (
        .i_req    (HBUSREQ),
        .i_ptr    (r_rrPtr),
        .o_winner (w_winner),
        .o_valid  (w_winValid)
    );

    // Classify the current edge: burst continuation, counted beat, error,
    // and whether the owner has exhausted its beat allowance while others wait.
    always_comb begin
        w_isBurst    = (HTRANS == HTRANS_SEQ) || (HTRANS == HTRANS_BUSY);
        w_isActive   = (HTRANS != HTRANS_IDLE) && (HTRANS != HTRANS_BUSY);
        w_isErr      = (HRESP == HRESP_ERROR);
        w_othersReq  = |(HBUSREQ & ~r_grant);
        w_beatLimit  = (r_beats == BEAT_LAST) && (r_state != LOCK) && w_othersReq;
        w_rearb      = HREADY && (!w_isBurst || w_beatLimit || w_isErr);
        w_ownerLocks = HLOCK[r_owner] && HBUSREQ[r_owner];
    end

    // Arbitration decision at a rearbitration point. A locking owner keeps
    // the bus (an error response cancels the lock instead); otherwise the
    // round-robin winner takes it, or the default master parks on it.
    always_comb begin
        w_nextState = r_state;
        w_nextGrant = r_grant;
        w_nextOwner = r_owner;
        w_nextPtr   = r_rrPtr;
        if (w_rearb) begin
            if ((r_state != PARK) && !w_isErr && w_ownerLocks) begin
                w_nextState = LOCK;
            end else if (w_winValid) begin
                w_nextState = GRANT;
                w_nextGrant = GRANT_ONE << w_winner;
                w_nextOwner = w_winner;
                w_nextPtr   = w_winner;
            end else begin
                w_nextState = PARK;
                w_nextGrant = DEF_GRANT;
                w_nextOwner = DEF_IDX;
            end
        end
    end

    // Beat counter restarts for every new owner and otherwise counts
    // NONSEQ/SEQ address phases, holding at the limit value.
    always_comb begin
        w_nextBeats = r_beats;
        if (w_nextGrant != r_grant) begin
            w_nextBeats = '0;
        end else if (HREADY && w_isActive && (r_beats != BEAT_LAST)) begin
            w_nextBeats = r_beats + 1'b1;
        end
    end

    // All arbiter state advances only on HREADY-high edges; ownership and
    // lock indication follow the previous grant to line up with the address phase.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_state    <= PARK;
            r_grant    <= DEF_GRANT;
            r_owner    <= DEF_IDX;
            r_rrPtr    <= DEF_IDX;
            r_beats    <= '0;
            r_master   <= DEF_IDX;
            r_mastLock <= 1'b0;
        end else if (HREADY) begin
            r_state    <= w_nextState;
            r_grant    <= w_nextGrant;
            r_owner    <= w_nextOwner;
            r_rrPtr    <= w_nextPtr;
            r_beats    <= w_nextBeats;
            r_master   <= r_owner;
            r_mastLock <= (r_state == LOCK);
        end
    end

    assign HGRANT    = r_grant;
    assign HMASTER   = r_master;
    assign HMASTLOCK = r_mastLock;

    a_grantOneHot : assert property (@(posedge HCLK) disable iff (HRESET) $onehot(r_grant));

endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// Testbench for ahb_bus_arbiter: a default instance (MaxBeats=16) and a
// short-limit instance (MaxBeats=4) share the same stimulus and are each
// compared against a behavioural arbiter model every cycle.
module tb_ahb_bus_arbiter;

    localparam int NM      = 3;
    localparam int DEF     = 0;
    localparam int BEATS_A = 16;
    localparam int BEATS_B = 4;

    localparam logic [1:0] T_IDLE   = 2'b00;
    localparam logic [1:0] T_NONSEQ = 2'b10;
    localparam logic [1:0] T_SEQ    = 2'b11;

    typedef struct packed {
        logic       rst;
        logic [2:0] busReq;
        logic [2:0] lockReq;
        logic [1:0] trans;
        logic       ready;
        logic       resp;
    } stim_t;

    typedef struct {
        stim_t      stim;
        logic [2:0] expGrant;
        logic [1:0] expMaster;
        logic       expLock;
    } vec_t;

    typedef struct {
        int owner;
        int ptr;
        int beats;
        int master;
        bit locked;
        bit parked;
        bit mastLock;
    } modelState_t;

    logic       clock;
    logic       reset;
    logic [2:0] busReq;
    logic [2:0] lockReq;
    logic [1:0] hTrans;
    logic       hReady;
    logic       hResp;
    logic [2:0] grantA;
    logic [2:0] grantB;
    logic [1:0] masterA;
    logic [1:0] masterB;
    logic       mastLockA;
    logic       mastLockB;

    int          nCompared;
    int          nMismatched;
    modelState_t modelA;
    modelState_t modelB;
    vec_t        vecs[$];
    stim_t       rs;

    ahb_bus_arbiter #(.NoOfMasters(NM), .DefaultMaster(DEF), .MaxBeats(BEATS_A)) dutA (
        .HCLK      (clock),
        .HRESET    (reset),
        .HBUSREQ   (busReq),
        .HLOCK     (lockReq),
        .HTRANS    (hTrans),
        .HREADY    (hReady),
        .HRESP     (hResp),
        .HGRANT    (grantA),
        .HMASTER   (masterA),
        .HMASTLOCK (mastLockA)
    );

    ahb_bus_arbiter #(.NoOfMasters(NM), .DefaultMaster(DEF), .MaxBeats(BEATS_B)) dutB (
        .HCLK      (clock),
        .HRESET    (reset),
        .HBUSREQ   (busReq),
        .HLOCK     (lockReq),
        .HTRANS    (hTrans),
        .HREADY    (hReady),
        .HRESP     (hResp),
        .HGRANT    (grantB),
        .HMASTER   (masterB),
        .HMASTLOCK (mastLockB)
    );

    // Free-running bus clock.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Safety net so a stuck run still ends with a visible failure.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: run did not reach the summary");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic modelState_t resetModel();
        modelState_t r;
        r.owner    = DEF;
        r.ptr      = DEF;
        r.beats    = 0;
        r.master   = DEF;
        r.locked   = 1'b0;
        r.parked   = 1'b1;
        r.mastLock = 1'b0;
        return r;
    endfunction

    // One bus edge of the arbiter rules, written directly from the protocol.
    function automatic modelState_t modelStep(modelState_t s, stim_t in, int maxBeats);
        modelState_t n;
        bit burst;
        bit err;
        bit others;
        bit rp;
        int win;
        int idx;
        n = s;
        if (in.rst) return resetModel();
        if (!in.ready) return s;
        burst  = (in.trans == 2'b01) || (in.trans == 2'b11);
        err    = in.resp;
        others = 1'b0;
        for (int i = 0; i < NM; i++) begin
            if (i != s.owner && in.busReq[i]) others = 1'b1;
        end
        rp = !burst || err || ((s.beats == maxBeats - 1) && !s.locked && others);
        n.master   = s.owner;
        n.mastLock = s.locked;
        if (rp) begin
            if (!s.parked && !err && in.lockReq[s.owner] && in.busReq[s.owner]) begin
                n.locked = 1'b1;
            end else begin
                win = -1;
                for (int k = 1; k <= NM; k++) begin
                    idx = (s.ptr + k) % NM;
                    if (win < 0 && in.busReq[idx]) win = idx;
                end
                n.locked = 1'b0;
                if (win >= 0) begin
                    n.owner  = win;
                    n.ptr    = win;
                    n.parked = 1'b0;
                end else begin
                    n.owner  = DEF;
                    n.parked = 1'b1;
                end
            end
        end
        if (n.owner != s.owner) begin
            n.beats = 0;
        end else if ((in.trans == 2'b10 || in.trans == 2'b11) && s.beats < maxBeats - 1) begin
            n.beats = s.beats + 1;
        end
        return n;
    endfunction

    function automatic stim_t mkStim(logic rst, logic [2:0] req, logic [2:0] lck,
                                     logic [1:0] trans, logic ready, logic resp);
        stim_t s;
        s.rst     = rst;
        s.busReq  = req;
        s.lockReq = lck;
        s.trans   = trans;
        s.ready   = ready;
        s.resp    = resp;
        return s;
    endfunction

    function automatic logic [2:0] ohOf(int idx);
        logic [2:0] v;
        v = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    function automatic void addVec(stim_t s, logic [2:0] g, logic [1:0] m, logic l);
        vec_t v;
        v.stim      = s;
        v.expGrant  = g;
        v.expMaster = m;
        v.expLock   = l;
        vecs.push_back(v);
    endfunction

    task automatic compareVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs away from the edge, then advance both models.
    task automatic applyStimulus(input stim_t s);
        @(negedge clock);
        reset   = s.rst;
        busReq  = s.busReq;
        lockReq = s.lockReq;
        hTrans  = s.trans;
        hReady  = s.ready;
        hResp   = s.resp;
        @(posedge clock);
        modelA = modelStep(modelA, s, BEATS_A);
        modelB = modelStep(modelB, s, BEATS_B);
        #1;
    endtask

    // Compare both instances against their models.
    task automatic checkOutput(input string tag);
        compareVal({tag, ".grantA"},    32'(grantA),    32'(ohOf(modelA.owner)));
        compareVal({tag, ".masterA"},   32'(masterA),   32'(modelA.master));
        compareVal({tag, ".mastLockA"}, 32'(mastLockA), 32'(modelA.mastLock));
        compareVal({tag, ".grantB"},    32'(grantB),    32'(ohOf(modelB.owner)));
        compareVal({tag, ".masterB"},   32'(masterB),   32'(modelB.master));
        compareVal({tag, ".mastLockB"}, 32'(mastLockB), 32'(modelB.mastLock));
    endtask

    task automatic runCycle(input stim_t s, input string tag);
        applyStimulus(s);
        checkOutput(tag);
    endtask

    initial begin
        nCompared   = 0;
        nMismatched = 0;
        reset       = 1'b1;
        busReq      = '0;
        lockReq     = '0;
        hTrans      = T_IDLE;
        hReady      = 1'b1;
        hResp       = 1'b0;
        modelA      = resetModel();
        modelB      = resetModel();

        // Reset, ten idle cycles, then two masters alternating NONSEQ/IDLE.
        addVec(mkStim(1, 3'b000, 3'b000, T_IDLE, 1, 0), 3'b001, 2'd0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            addVec(mkStim(0, 3'b000, 3'b000, T_IDLE, 1, 0), 3'b001, 2'd0, 1'b0);
        end
        addVec(mkStim(0, 3'b110, 3'b000, T_NONSEQ, 1, 0), 3'b010, 2'd0, 1'b0);
        addVec(mkStim(0, 3'b110, 3'b000, T_IDLE,   1, 0), 3'b100, 2'd1, 1'b0);
        addVec(mkStim(0, 3'b110, 3'b000, T_NONSEQ, 1, 0), 3'b010, 2'd2, 1'b0);
        addVec(mkStim(0, 3'b110, 3'b000, T_IDLE,   1, 0), 3'b100, 2'd1, 1'b0);
        addVec(mkStim(0, 3'b000, 3'b000, T_IDLE,   1, 0), 3'b001, 2'd2, 1'b0);
        addVec(mkStim(0, 3'b000, 3'b000, T_IDLE,   1, 0), 3'b001, 2'd0, 1'b0);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].stim);
            checkOutput($sformatf("vec%0d", i));
            compareVal($sformatf("vec%0d.tblGrant", i),  32'(grantA),    32'(vecs[i].expGrant));
            compareVal($sformatf("vec%0d.tblMaster", i), 32'(masterA),   32'(vecs[i].expMaster));
            compareVal($sformatf("vec%0d.tblLock", i),   32'(mastLockA), 32'(vecs[i].expLock));
        end

        // Master1 8-beat burst; master2 starts asking after the NONSEQ beat.
        runCycle(mkStim(0, 3'b010, 3'b000, T_IDLE,   1, 0), "burst.req");
        runCycle(mkStim(0, 3'b010, 3'b000, T_NONSEQ, 1, 0), "burst.nonseq");
        for (int i = 0; i < 7; i++) runCycle(mkStim(0, 3'b110, 3'b000, T_SEQ, 1, 0), "burst.seq");
        compareVal("burst.heldToEnd", 32'(grantA), 32'(3'b010));
        runCycle(mkStim(0, 3'b110, 3'b000, T_IDLE, 1, 0), "burst.end");
        compareVal("burst.handover", 32'(grantA), 32'(3'b100));

        // Beat limit: the MaxBeats=4 instance hands over after four beats.
        runCycle(mkStim(1, 3'b000, 3'b000, T_IDLE,   1, 0), "limit.rst");
        runCycle(mkStim(0, 3'b010, 3'b000, T_IDLE,   1, 0), "limit.req");
        runCycle(mkStim(0, 3'b010, 3'b000, T_NONSEQ, 1, 0), "limit.nonseq");
        runCycle(mkStim(0, 3'b110, 3'b000, T_SEQ,    1, 0), "limit.seq1");
        runCycle(mkStim(0, 3'b110, 3'b000, T_SEQ,    1, 0), "limit.seq2");
        compareVal("limit.heldB", 32'(grantB), 32'(3'b010));
        runCycle(mkStim(0, 3'b110, 3'b000, T_SEQ,    1, 0), "limit.seq3");
        compareVal("limit.cutB", 32'(grantB), 32'(3'b100));
        compareVal("limit.keptA", 32'(grantA), 32'(3'b010));
        for (int i = 0; i < 5; i++) runCycle(mkStim(0, 3'b110, 3'b000, T_SEQ, 1, 0), "limit.seqN");
        compareVal("limit.fullBurstA", 32'(grantA), 32'(3'b010));
        runCycle(mkStim(0, 3'b110, 3'b000, T_IDLE, 1, 0), "limit.end");
        compareVal("limit.endA", 32'(grantA), 32'(3'b100));

        // Locked sequence of 20 beats, ended by an ERROR response.
        runCycle(mkStim(1, 3'b000, 3'b000, T_IDLE,   1, 0), "lock.rst");
        runCycle(mkStim(0, 3'b010, 3'b010, T_IDLE,   1, 0), "lock.req");
        runCycle(mkStim(0, 3'b110, 3'b010, T_NONSEQ, 1, 0), "lock.enter");
        for (int i = 0; i < 20; i++) begin
            runCycle(mkStim(0, 3'b110, 3'b010, T_NONSEQ, 1, 0), "lock.beat");
            compareVal($sformatf("lock.grantA%0d", i),  32'(grantA),    32'(3'b010));
            compareVal($sformatf("lock.mlockA%0d", i),  32'(mastLockA), 32'(1'b1));
            compareVal($sformatf("lock.grantB%0d", i),  32'(grantB),    32'(3'b010));
        end
        runCycle(mkStim(0, 3'b110, 3'b010, T_IDLE, 1, 1), "lock.error");
        compareVal("lock.afterErrA", 32'(grantA), 32'(3'b100));
        compareVal("lock.afterErrB", 32'(grantB), 32'(3'b100));

        // Wait states freeze everything despite pending requests.
        for (int i = 0; i < 5; i++) begin
            runCycle(mkStim(0, 3'b011, 3'b000, T_IDLE, 0, 0), "wait.low");
            compareVal($sformatf("wait.grant%0d", i),  32'(grantA),  32'(3'b100));
            compareVal($sformatf("wait.master%0d", i), 32'(masterA), 32'(2'd1));
        end
        runCycle(mkStim(0, 3'b011, 3'b000, T_IDLE, 1, 0), "wait.release");
        compareVal("wait.releaseGrant", 32'(grantA), 32'(3'b001));

        // Reset in the middle of a burst.
        runCycle(mkStim(0, 3'b010, 3'b000, T_IDLE,   1, 0), "rstmid.req");
        runCycle(mkStim(0, 3'b010, 3'b000, T_NONSEQ, 1, 0), "rstmid.nonseq");
        runCycle(mkStim(0, 3'b110, 3'b000, T_SEQ,    1, 0), "rstmid.seq");
        compareVal("rstmid.before", 32'(grantA), 32'(3'b010));
        runCycle(mkStim(1, 3'b110, 3'b000, T_SEQ,    1, 0), "rstmid.rst");
        compareVal("rstmid.grant",  32'(grantA),    32'(3'b001));
        compareVal("rstmid.master", 32'(masterA),   32'(2'd0));
        compareVal("rstmid.lock",   32'(mastLockA), 32'(1'b0));

        // Randomized traffic against both models.
        for (int i = 0; i < 2000; i++) begin
            rs.rst     = ($urandom_range(0, 99) == 0);
            rs.busReq  = 3'($urandom_range(0, 7));
            rs.lockReq = ($urandom_range(0, 1) == 0) ? 3'($urandom_range(0, 7)) & rs.busReq
                                                     : 3'($urandom_range(0, 7));
            rs.trans   = ($urandom_range(0, 1) == 0) ? T_SEQ : 2'($urandom_range(0, 3));
            rs.ready   = ($urandom_range(0, 3) != 0);
            rs.resp    = ($urandom_range(0, 15) == 0);
            runCycle(rs, $sformatf("rand%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
